cam_capture: RTL
================

// Module: cam_capture
// PURPOSE
//  Parametrised camera parallel-port capture, fully in the system clock domain.
//  Oversamples the camera pixel clock, assembles BYTES_PER_PIXEL bytes into one pixel and tags each pixel with x/y.
//  Flags malformed lines; also generates camera XCLK and the power-up hold-off.
//  Sits between the camera pins and the frame-buffer write port.
// PARAMETERS
//  DATA_WIDTH      8           camera data bus width
//  BYTES_PER_PIXEL 2           bus beats per pixel (1..4); first beat lands in MSBs
//  H_ACTIVE        320         pixels per line kept; excess pixels dropped
//  V_ACTIVE        240         lines per frame kept; excess lines dropped
//  SYNC_STAGES     2           synchroniser depth on all camera inputs (>=2)
//  XCLK_DIV        4           clk_65mhz cycles per XCLK period (even, >=2)
//  STARTUP_DELAY   65_000_000  cycles after reset before cam_ready_out rises
// PORTS
//  clk_65mhz        in   1                          system clock
//  rst_in           in   1                          synchronous active-high reset
//  cam_pclk_in      in   1                          camera pixel clock (async)
//  cam_vsync_in     in   1                          camera VSYNC, high = blanking
//  cam_href_in      in   1                          camera HREF, high = active bytes
//  cam_data_in      in   DATA_WIDTH                 camera data bus
//  cam_xclk_out     out  1                          camera master clock
//  cam_ready_out    out  1                          high once STARTUP_DELAY has elapsed
//  pixel_out        out  DATA_WIDTH*BYTES_PER_PIXEL assembled pixel
//  hcount_out       out  $clog2(H_ACTIVE)           x of pixel_out
//  vcount_out       out  $clog2(V_ACTIVE)           y of pixel_out
//  pixel_valid_out  out  1                          1-cycle strobe, pixel/x/y valid
//  frame_done_out   out  1                          1-cycle strobe at end of frame
//  line_err_out     out  1                          1-cycle strobe, line length != H_ACTIVE or partial pixel
// BEHAVIOUR
//  - Reset: all outputs 0; counters 0; FSM -> WAIT_VSYNC; XCLK divider and startup counter restart.
//    Applies identically mid-frame; the partial frame is discarded and no frame_done is emitted.
//  - Inputs pass SYNC_STAGES flops.
//  - Sample event = rising edge of synced pclk; href/data sampled from the same stage.
//  - cam_pclk_in must be <= clk_65mhz/4.
//  - FSM states:
//    WAIT_VSYNC: wait for vsync high (never start mid-frame); go to WAIT_FRAME.
//    WAIT_FRAME: on vsync low, go to ACTIVE with x=y=0 and byte index 0.
//    ACTIVE: on vsync high, pulse frame_done_out one cycle, then go to WAIT_FRAME.
//  - In ACTIVE, each sample with href high shifts data into the pixel register.
//  - On the last beat: pixel_valid_out pulses 1 cycle later, while x<H_ACTIVE and y<V_ACTIVE;
//    x increments, saturating at H_ACTIVE.
//  - Latency: SYNC_STAGES+2 clk_65mhz cycles from the last-beat pclk edge to pixel_valid_out.
//  - Falling href (on a sample event):
//    - y increments if the line had >=1 pixel; y saturates at V_ACTIVE.
//    - x and byte index clear.
//    - line_err_out pulses if the pixel count != H_ACTIVE or the byte index != 0.
//    - The partial pixel is dropped.
//  - vsync rising while href is still high: the line ends as on falling href (err rules apply), then frame_done.
//  - XCLK: 50% duty divide of clk_65mhz by XCLK_DIV, free-running after reset.
//  - cam_ready_out: rises at STARTUP_DELAY and holds until reset.
//  - No pixel_valid_out while cam_ready_out is low.
// CONFIGURATION
//  CAM_DECIMATE_EN defined:
//  - Only pixels with x and y both even are emitted; hcount_out=x/2, vcount_out=y/2.
//  - hcount_out/vcount_out widths shrink by 1.
//  - line_err_out still checks the full H_ACTIVE.
//  CAM_DECIMATE_EN undefined: every in-window pixel is emitted at full coordinates.
// STRUCTURE
//  - cam_pkg: capture_state_t enum (WAIT_VSYNC, WAIT_FRAME, ACTIVE) and the byte-order constant.
//  - Sub-module cam_input_sync: SYNC_STAGES-deep synchroniser for pclk/vsync/href/data
//    plus pclk rising-edge detector; output is a 1-cycle sample strobe.
//  - Top: FSM, byte assembler, x/y counters, XCLK divider, startup counter.
// TESTING
//  1. Reset held, then released; STARTUP_DELAY=100 -> all outputs 0 and cam_ready_out rises at cycle 100.
//     XCLK period = 4 cycles.
//  2. One frame of 4x3 pixels, bytes AB,CD per pixel (H_ACTIVE=4, V_ACTIVE=3, pclk=clk/8)
//     -> 12 strobes, pixel_out=16'hABCD, x/y raster order 0..3/0..2.
//     Exactly 1 frame_done, no line_err.
//  3. Line with 3 bytes (1.5 pixels) -> 1 pixel strobe; line_err_out pulses at href fall; next line y=1, x=0.
//  4. Line with 6 pixels at H_ACTIVE=4 -> 4 strobes, x max 3, line_err_out pulses once.
//  5. Reset asserted mid-line, then a fresh frame -> no strobes until vsync high->low; first pixel x=y=0.
//  6. CAM_DECIMATE_EN, 4x4 frame -> 4 strobes at (0,0),(1,0),(0,1),(1,1).

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path.
// CAM_DECIMATE_EN selects 2:1 decimation in x and y, which narrows the output coordinates.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } capture_state_t;

    localparam bit FIRST_BEAT_MSB = 1'b1;

`ifdef CAM_DECIMATE_EN
    localparam bit DECIMATE = 1'b1;
`else
    localparam bit DECIMATE = 1'b0;
`endif

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int coord_w(input int n);
        return DECIMATE ? cnt_w((n + 1) / 2) : cnt_w(n);
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera pins plus the pixel write stream; master = capture block, slave = sensor/consumer side.
// Coordinate widths follow cam_pkg::coord_w, so they shrink under CAM_DECIMATE_EN.
interface cam_capture_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 240
);
    import cam_pkg::*;

    localparam int PW  = DATA_WIDTH * BYTES_PER_PIXEL;
    localparam int HCW = coord_w(H_ACTIVE);
    localparam int VCW = coord_w(V_ACTIVE);

    logic                  cam_pclk_in;
    logic                  cam_vsync_in;
    logic                  cam_href_in;
    logic [DATA_WIDTH-1:0] cam_data_in;
    logic                  cam_xclk_out;
    logic                  cam_ready_out;
    logic [PW-1:0]         pixel_out;
    logic [HCW-1:0]        hcount_out;
    logic [VCW-1:0]        vcount_out;
    logic                  pixel_valid_out;
    logic                  frame_done_out;
    logic                  line_err_out;

    modport master (
        input  cam_pclk_in, cam_vsync_in, cam_href_in, cam_data_in,
        output cam_xclk_out, cam_ready_out, pixel_out, hcount_out, vcount_out,
               pixel_valid_out, frame_done_out, line_err_out
    );

    modport slave (
        output cam_pclk_in, cam_vsync_in, cam_href_in, cam_data_in,
        input  cam_xclk_out, cam_ready_out, pixel_out, hcount_out, vcount_out,
               pixel_valid_out, frame_done_out, line_err_out
    );

endinterface

// File: rtl/cam_input_sync.sv
// Synchronises camera pclk/vsync/href/data and emits a 1-cycle strobe per pclk rising edge.
// Latency SYNC_STAGES+1 cycles; no backpressure, the camera cannot be stalled.
module cam_input_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_65mhz,
    input  logic                  rst_in,
    input  logic                  pclk,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  sample_stb,
    output logic                  vsync_s,
    output logic                  href_s,
    output logic [DATA_WIDTH-1:0] data_s
);
    localparam int SW = DATA_WIDTH + 3;

    logic [SW-1:0] stage [SYNC_STAGES];
    logic          pclk_d;

    // href/data are taken from the same stage as the pclk edge so they stay aligned with the strobe
    always_ff @(posedge clk_65mhz) begin
        if (rst_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            pclk_d     <= 1'b0;
            sample_stb <= 1'b0;
            vsync_s    <= 1'b0;
            href_s     <= 1'b0;
            data_s     <= '0;
        end else begin
            stage[0] <= {pclk, vsync, href, data};
            for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            pclk_d     <= stage[SYNC_STAGES-1][SW-1];
            sample_stb <= stage[SYNC_STAGES-1][SW-1] & ~pclk_d;
            vsync_s    <= stage[SYNC_STAGES-1][SW-2];
            href_s     <= stage[SYNC_STAGES-1][SW-3];
            data_s     <= stage[SYNC_STAGES-1][DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cam_capture.sv
// Camera parallel-port capture: pixel assembly, x/y tagging, line checks, XCLK and power-up hold-off.
// Latency SYNC_STAGES+2 cycles pclk edge to pixel strobe; no backpressure. CAM_DECIMATE_EN keeps even x/y only.
module cam_capture
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 240,
    parameter int SYNC_STAGES     = 2,
    parameter int XCLK_DIV        = 4,
    parameter int STARTUP_DELAY   = 65_000_000
) (
    input  logic          clk_65mhz,
    input  logic          rst_in,
    cam_capture_if.master cam
);
    localparam int PW  = DATA_WIDTH * BYTES_PER_PIXEL;
    localparam int HW  = coord_w(H_ACTIVE);
    localparam int VW  = coord_w(V_ACTIVE);
    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 1);
    localparam int SDW = $clog2(STARTUP_DELAY + 1);
    localparam int XCW = cnt_w(XCLK_DIV / 2);

    localparam logic [1:0]     LAST_BEAT = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [XW-1:0]  X_MAX     = XW'(H_ACTIVE);
    localparam logic [YW-1:0]  Y_MAX     = YW'(V_ACTIVE);
    localparam logic [SDW-1:0] SD_LAST   = SDW'(STARTUP_DELAY - 1);
    localparam logic [XCW-1:0] XC_HALF   = XCW'(XCLK_DIV / 2 - 1);

    logic                  stb, vs, hr;
    logic [DATA_WIDTH-1:0] dat;

    cam_input_sync #(.DATA_WIDTH(DATA_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_65mhz (clk_65mhz),
        .rst_in    (rst_in),
        .pclk      (cam.cam_pclk_in),
        .vsync     (cam.cam_vsync_in),
        .href      (cam.cam_href_in),
        .data      (cam.cam_data_in),
        .sample_stb(stb),
        .vsync_s   (vs),
        .href_s    (hr),
        .data_s    (dat)
    );

    capture_state_t state, state_nxt;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [1:0]     byte_idx;
    logic           x_ovf, href_d;
    logic [PW-1:0]  pix_sr, pix_nxt;
    logic [SDW-1:0] start_cnt;
    logic [XCW-1:0] xclk_cnt;
    logic           beat, last_beat, line_end, line_bad, emit, keep;

    always_ff @(posedge clk_65mhz) begin
        if (rst_in) state <= WAIT_VSYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_VSYNC: if (vs)  state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (!vs) state_nxt = ACTIVE;
            ACTIVE:     if (vs)  state_nxt = WAIT_FRAME;
            default:             state_nxt = WAIT_VSYNC;
        endcase
    end

    // vsync takes priority over a coincident sample: a line still open at vsync is closed, not extended
    assign beat      = (state == ACTIVE) && !vs && stb && hr;
    assign last_beat = beat && (byte_idx == LAST_BEAT);
    assign line_end  = (state == ACTIVE) && href_d && (vs || (stb && !hr));
    assign line_bad  = (x != X_MAX) || x_ovf || (byte_idx != 2'd0);
    assign keep      = DECIMATE ? (!x[0] && !y[0]) : 1'b1;
    assign emit      = last_beat && (x < X_MAX) && (y < Y_MAX) && keep && cam.cam_ready_out;
    assign pix_nxt   = FIRST_BEAT_MSB ? PW'({pix_sr, dat}) : PW'({dat, pix_sr} >> DATA_WIDTH);

    always_ff @(posedge clk_65mhz) begin
        if (rst_in) begin
            x                   <= '0;
            y                   <= '0;
            byte_idx            <= 2'd0;
            x_ovf               <= 1'b0;
            href_d              <= 1'b0;
            pix_sr              <= '0;
            cam.pixel_out       <= '0;
            cam.hcount_out      <= '0;
            cam.vcount_out      <= '0;
            cam.pixel_valid_out <= 1'b0;
            cam.frame_done_out  <= 1'b0;
            cam.line_err_out    <= 1'b0;
        end else begin
            cam.pixel_valid_out <= 1'b0;
            cam.frame_done_out  <= 1'b0;
            cam.line_err_out    <= 1'b0;
            if (state != ACTIVE) begin
                x        <= '0;
                y        <= '0;
                byte_idx <= 2'd0;
                x_ovf    <= 1'b0;
                href_d   <= 1'b0;
            end else begin
                if (stb && !vs) href_d <= hr;
                if (beat) begin
                    pix_sr   <= pix_nxt;
                    byte_idx <= last_beat ? 2'd0 : byte_idx + 2'd1;
                end
                // x parks at H_ACTIVE; x_ovf remembers that extra pixels arrived so the length check still fires
                if (last_beat) begin
                    if (x == X_MAX) x_ovf <= 1'b1;
                    else            x     <= x + XW'(1);
                end
                if (emit) begin
                    cam.pixel_out       <= pix_nxt;
                    cam.hcount_out      <= HW'(x >> DECIMATE);
                    cam.vcount_out      <= VW'(y >> DECIMATE);
                    cam.pixel_valid_out <= 1'b1;
                end
                if (line_end) begin
                    x        <= '0;
                    byte_idx <= 2'd0;
                    x_ovf    <= 1'b0;
                    href_d   <= 1'b0;
                    if ((x != '0 || x_ovf) && y != Y_MAX) y <= y + YW'(1);
                    cam.line_err_out <= line_bad;
                end
                if (vs) cam.frame_done_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_65mhz) begin
        if (rst_in) begin
            xclk_cnt          <= '0;
            cam.cam_xclk_out  <= 1'b0;
            start_cnt         <= '0;
            cam.cam_ready_out <= 1'b0;
        end else begin
            if (xclk_cnt == XC_HALF) begin
                xclk_cnt         <= '0;
                cam.cam_xclk_out <= ~cam.cam_xclk_out;
            end else begin
                xclk_cnt <= xclk_cnt + XCW'(1);
            end
            if (!cam.cam_ready_out) begin
                start_cnt <= start_cnt + SDW'(1);
                if (start_cnt == SD_LAST) cam.cam_ready_out <= 1'b1;
            end
        end
    end

endmodule
